// File: rtl/sa_ram_rws_param.sv
// sa_ram_rws_param: parametrised 1R1W RAM with bit-masked writes, post-reset hardware clear and range protection
//   clk            single clock, all state on rising edge
//   rstn           asynchronous active-low reset; restarts the clear sequence
//   ra, re         read address / enable; address registered, data valid one cycle later
//   dout, dout_vld read data (zero while not ready or out of range) and its strobe
//   wa, we, di     write address / enable / data
//   wmask          per-bit write enable
//   ready          high once every entry has been zeroed
//   acc_err        sticky: access while clearing, or address >= DEPTH
//   pwrbus_ram_pd  power-down bus, functionally ignored
//   Define SA_RAM_RWS_PARAM_DOUT_REG_EN to add an output register stage (2-cycle read latency).
module sa_ram_rws_param #(
  parameter int DW    = 7,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic [DW-1:0] wmask,
  output logic          ready,
  output logic          acc_err,
  input  logic [31:0]   pwrbus_ram_pd
);
  localparam logic [0:0]    CLEAR = 1'b0;
  localparam logic [0:0]    RUN   = 1'b1;
  localparam logic [AW:0]   LIM   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH-1);
  logic [DW-1:0] mem [DEPTH];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_q, clr_d, ra_q, ra_d;
  logic          vld_q, vld_d, err_q, err_d;
  logic          run, wa_ok, ra_ok, rq_ok, mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd, rd;
  logic          unused_pd;
  assign unused_pd = ^pwrbus_ram_pd;
  assign run   = state_q == RUN;
  assign wa_ok = {1'b0, wa} < LIM;
  assign ra_ok = {1'b0, ra} < LIM;
  assign rq_ok = {1'b0, ra_q} < LIM;
  always_comb begin
    state_d = (!run && clr_q == LAST) ? RUN : state_q;
    clr_d   = run ? clr_q : clr_q + 1'b1;
    ra_d    = (run && re) ? ra : ra_q;
    vld_d   = run && re;
    err_d   = err_q | (!run & (re | we)) | (run & ((we & !wa_ok) | (re & !ra_ok)));
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      ra_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ra_q    <= ra_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end
  // The clear sequencer owns the single write port until ready.
  assign mem_we = !run || (we && wa_ok);
  assign mem_wa = run ? wa : clr_q;
  assign mem_wd = run ? (mem[wa] & ~wmask) | (di & wmask) : '0;
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end
  // Combinational read of the registered address gives write-first behaviour for free.
  assign rd = (run && rq_ok) ? mem[ra_q] : '0;
`ifdef SA_RAM_RWS_PARAM_DOUT_REG_EN
  logic [DW-1:0] dout_q;
  logic          dvld_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= '0;
      dvld_q <= 1'b0;
    end else begin
      dvld_q <= vld_q;
      if (vld_q) dout_q <= rd;
    end
  end
  assign dout     = dout_q;
  assign dout_vld = dvld_q;
`else
  assign dout     = rd;
  assign dout_vld = vld_q;
`endif
  assign ready   = run;
  assign acc_err = err_q;
endmodule

// File: tb/tb_sa_ram_rws_param.sv
// tb_sa_ram_rws_param: scoreboard bench for sa_ram_rws_param (DEPTH=200, AW=8 to reach out-of-range addresses)
module tb_sa_ram_rws_param;
  localparam int DW = 7, AW = 8, DEPTH = 200;
`ifdef SA_RAM_RWS_PARAM_DOUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif
  logic          clk = 1'b0, rstn = 1'b0, re = 1'b0, we = 1'b0;
  logic [AW-1:0] ra = '0, wa = '0;
  logic [DW-1:0] di = '0, wmask = '0, dout;
  logic          dout_vld, ready, acc_err;
  logic [31:0]   pwrbus_ram_pd = '0;
  int            checks = 0, failures = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            run_m = 1'b0, exp_err = 1'b0;
  logic [DW-1:0] old_v, new_v;

  sa_ram_rws_param #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout), .dout_vld(dout_vld),
    .wa(wa), .we(we), .di(di), .wmask(wmask), .ready(ready), .acc_err(acc_err),
    .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dout_vld) begin
      if (exp_q.size() == 0) check("vld_unexpected", 32'(dout_vld), 32'(0));
      else check("dout", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input bit r, input int a_r, input bit w, input int a_w,
                     input logic [DW-1:0] d, input logic [DW-1:0] m);
    re = r; ra = AW'(a_r); we = w; wa = AW'(a_w); di = d; wmask = m;
    if (!run_m) begin
      if (r || w) exp_err = 1'b1;
    end else begin
      if (w) begin
        if (a_w < DEPTH) model[a_w] = (model[a_w] & ~m) | (d & m);
        else exp_err = 1'b1;
      end
      if (r) begin
        exp_q.push_back(a_r < DEPTH ? model[a_r] : '0);
        if (a_r >= DEPTH) exp_err = 1'b1;
      end
    end
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, '0, '0);
  endtask

  task automatic reset_start();
    idle(3);
    check("sb_empty", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    rstn = 1'b0; run_m = 1'b0; exp_err = 1'b0;
    #2;
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_err", 32'(acc_err), 32'(0));
    check("rst_vld", 32'(dout_vld), 32'(0));
    check("rst_dout", 32'(dout), 32'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic wait_ready(input int already);
    int n = already;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == DEPTH - 1) check("ready_early", 32'(ready), 32'(0));
    end while (!ready && n < 1000);
    check("ready_lat", 32'(n), 32'(DEPTH));
    run_m = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset, clear latency, every entry reads zero
    reset_start();
    wait_ready(0);
    for (int i = 0; i < DEPTH; i++) cyc(1, i, 0, 0, '0, '0);
    idle(3);
    check("sb_drain_clear", 32'(exp_q.size()), 32'(0));
    // full write, masked write
    cyc(0, 0, 1, 5, 7'h55, 7'h7F);
    cyc(1, 5, 0, 0, '0, '0);
    cyc(0, 0, 1, 5, 7'h2A, 7'h0F);
    cyc(1, 5, 0, 0, '0, '0);
    check("masked_model", 32'(model[5]), 32'(7'h5A));
    cyc(0, 0, 1, 5, 7'h7F, 7'h00);
    cyc(1, 5, 0, 0, '0, '0);
    // write-first on same address, independent different addresses
    cyc(1, 9, 1, 9, 7'h33, 7'h7F);
    cyc(1, 5, 1, 6, 7'h44, 7'h7F);
    cyc(1, 6, 0, 0, '0, '0);
    // hold behaviour: later write to the addressed entry
    cyc(0, 0, 1, 3, 7'h11, 7'h7F);
    cyc(1, 3, 0, 0, '0, '0);
    cyc(0, 0, 1, 3, 7'h22, 7'h7F);
    idle(3);
    old_v = 7'h11; new_v = 7'h22;
    check("hold_dout", 32'(dout), 32'(REG ? old_v : new_v));
    check("hold_vld", 32'(dout_vld), 32'(0));
    cyc(1, 3, 0, 0, '0, '0);
    idle(3);
    check("reread_dout", 32'(dout), 32'(7'h22));
    check("err_clean", 32'(acc_err), 32'(exp_err));
    // random traffic with address overlap
    for (int k = 0; k < 200; k++) begin
      int a = $urandom_range(0, DEPTH - 1);
      int b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, DEPTH - 1);
      cyc(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), b, DW'($urandom), DW'($urandom));
    end
    idle(3);
    check("err_after_rand", 32'(acc_err), 32'(exp_err));
    // out of range, top entry boundary
    cyc(0, 0, 1, DEPTH - 1, 7'h6B, 7'h7F);
    cyc(1, DEPTH - 1, 0, 0, '0, '0);
    cyc(1, 210, 1, 210, 7'h7F, 7'h7F);
    idle(3);
    check("oor_err", 32'(acc_err), 32'(1));
    cyc(1, DEPTH - 1, 0, 0, '0, '0);
    idle(20);
    check("oor_err_sticky", 32'(acc_err), 32'(exp_err));
    // access during clear is ignored and flagged
    reset_start();
    idle(9);
    cyc(1, 3, 1, 3, 7'h7F, 7'h7F);
    idle(1);
    check("clr_err", 32'(acc_err), 32'(1));
    check("clr_vld", 32'(dout_vld), 32'(0));
    wait_ready(11);
    cyc(1, 3, 0, 0, '0, '0);
    idle(3);
    check("clr_err_sticky", 32'(acc_err), 32'(exp_err));
    // reset pulse mid-clear restarts the sequence and clears the flag
    reset_start();
    idle(9);
    cyc(0, 0, 1, 20, 7'h01, 7'h7F);
    idle(40);
    check("mid_ready", 32'(ready), 32'(0));
    check("mid_err", 32'(acc_err), 32'(1));
    reset_start();
    wait_ready(0);
    check("post_err", 32'(acc_err), 32'(0));
    cyc(1, 20, 0, 0, '0, '0);
    idle(4);
    check("sb_final", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sa_ram_rws_param.md
Name: sa_ram_rws_param

Overview:
Parametrised successor to the fixed-size 1R1W FPGA RAM models. It provides one write port and one read port with a registered read address, and adds:
- a per-bit write mask
- a read-valid strobe
- a post-reset hardware clear sequencer that zeroes every entry
- out-of-range address protection

It sits in the small-config RAM model library and is instantiated by datapath buffers that need known-zero contents after reset.

Parameters:
DW, 7, data width in bits (1..512)
AW, 8, address width in bits
DEPTH, 256, number of entries; must satisfy 2 <= DEPTH <= 2**AW (need not be a power of two)

Ports:
clk  input  1  single clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
ra  input  AW  read address
re  input  1  read enable
dout  output  DW  read data
dout_vld  output  1  read data valid strobe
wa  input  AW  write address
we  input  1  write enable
di  input  DW  write data
wmask  input  DW  per-bit write enable; bit i=1 writes di[i]
ready  output  1  high once the clear sequence is complete; accesses accepted only when high
acc_err  output  1  sticky access-error flag
pwrbus_ram_pd  input  32  power-down bus; functionally ignored, kept for interface compatibility

Behaviour:
- Reset: rstn low asynchronously forces:
  - state=CLEAR, clr_addr=0
  - ra_d=0, ready=0, dout_vld=0, acc_err=0
  - dout reads 0 (gated while ready=0)
- Memory array contents are not reset directly; they are zeroed by the CLEAR state.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes all-zero to M[clr_addr], then clr_addr++.
  - When clr_addr==DEPTH-1 is written, next state=RUN and ready=1 from the following cycle.
  - First rising edge after rstn deassertion clears entry 0; ready rises exactly DEPTH cycles after that edge.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR at address 0.
- During CLEAR:
  - re and we are ignored (no write, ra_d holds, dout_vld=0).
  - Any re or we sets acc_err.
- RUN write: when we=1 and wa<DEPTH, M[wa] <= (M[wa] & ~wmask) | (di & wmask).
  - wmask=0 is a legal no-op.
- RUN read: when re=1, ra_d <= ra, and dout_vld is high for exactly the next cycle.
  - dout = M[ra_d] combinationally, i.e. 1-cycle latency from re.
  - dout holds the last addressed entry while re=0 and tracks later writes to that entry.
- Read-during-write, same address, same cycle: write-first; dout in the next cycle shows the newly written (masked) data.
- Out of range:
  - we with wa>=DEPTH: write dropped, acc_err set.
  - re with ra>=DEPTH: ra_d captured, dout forced to 0, dout_vld still pulses, acc_err set.
- acc_err is sticky and cleared only by rstn.
- Simultaneous re and we at different addresses are independent; no contention.

Optional Feature:
SA_RAM_RWS_PARAM_DOUT_REG_EN
- Defined: adds an output register stage. dout and dout_vld are delayed one extra cycle (2-cycle read latency). The register:
  - resets to 0
  - loads only on the delayed read strobe
  - holds between reads, so later writes to the same entry are not reflected until the next read
- Undefined: 1-cycle combinational-output behaviour as above.

Test Plan:
1. Reset then idle, DEPTH=256 → ready=0 for 256 cycles after the first post-reset edge, then ready=1; reading all 256 addresses returns 0 with one dout_vld per re.
2. Write wa=5, di=7'h55, wmask=7'h7F, then read ra=5 → next cycle dout=7'h55 and dout_vld=1. Then write di=7'h2A, wmask=7'h0F and read → dout=7'h5A.
3. Same cycle: we at wa=9 with di=7'h33 and re at ra=9 → next-cycle dout=7'h33 (write-first).
4. DEPTH=200, AW=8: we at wa=210 and re at ra=210 → no write, dout=0, dout_vld=1, acc_err=1 and it stays 1 until rstn.
5. re/we asserted at cycle 10 of CLEAR → no access, acc_err=1. Then rstn pulsed low at cycle 50 → acc_err=0, ready rises 256 cycles after release.
6. With SA_RAM_RWS_PARAM_DOUT_REG_EN: write 7'h11 to addr 3, read addr 3 → dout=7'h11 and dout_vld=1 two cycles after re. A subsequent write of 7'h22 to addr 3 leaves dout=7'h11 until addr 3 is read again.
